// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file and auto-incrementing pointer.
// SCL/SDA are oversampled on clk; SDA is driven open-drain via sda_oe.
module i2c_slave_regfile #(
  parameter logic [6:0] SLV_ADDR = 7'h3c,
  parameter int         MEM_AW   = 8,
  parameter int         HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              host_we,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_pulse,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int HW    = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic r_scl_m, r_scl_s, r_scl_d;
  logic r_sda_m, r_sda_s, r_sda_d;

  logic [2:0]        r_bcnt;
  logic [6:0]        r_shift;
  logic [7:0]        r_tx;
  logic              r_rw;
  logic [MEM_AW-1:0] r_ptr;
  logic              r_busy;
  logic              r_sda_oe;
  logic              r_pend;
  logic              r_hold_act;
  logic [HW-1:0]     r_hold_cnt;
  logic              r_wr_pulse;
  logic [MEM_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_host_rdata;
  logic [7:0]        r_mem [DEPTH];

  logic       w_scl_rise, w_scl_fall;
  logic       w_start, w_stop;
  logic       w_last;
  logic [7:0] w_byte;
  logic       w_bit, w_tx_bit;
  logic       w_match, w_ptr_ld, w_wr;
  logic       w_pend, w_rd_load;

  // Bus idle level is high, so the synchronisers reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_scl_m, r_scl_s, r_scl_d} <= 3'b111;
      {r_sda_m, r_sda_s, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_m, r_scl_s, r_scl_d} <= {scl_i, r_scl_m, r_scl_s};
      {r_sda_m, r_sda_s, r_sda_d} <= {sda_i, r_sda_m, r_sda_s};
    end
  end

  assign w_scl_rise = r_scl_s & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s & r_scl_d;
  assign w_start    = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
  assign w_stop     = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;
  assign w_last     = (r_bcnt == 3'd7);
  assign w_byte     = {r_shift, r_sda_s};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_bit    = 1'b0;
    w_tx_bit = 1'b0;
    w_match  = 1'b0;
    w_ptr_ld = 1'b0;
    w_wr     = 1'b0;
    w_pend   = 1'b0;
    if (w_stop) begin
      w_nxt = S_IDLE;
    end else if (w_start) begin
      w_nxt = S_ADDR;
    end else if (w_scl_rise) begin
      unique case (r_state)
        S_ADDR: begin
          w_bit = 1'b1;
          if (w_last) begin
            if (w_byte[7:1] == SLV_ADDR) begin
              w_nxt   = S_ADDR_ACK;
              w_match = 1'b1;
            end else begin
              w_nxt = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: w_nxt = r_rw ? S_RDATA : S_PTR;
        S_PTR: begin
          w_bit = 1'b1;
          if (w_last) begin
            w_nxt    = S_PTR_ACK;
            w_ptr_ld = 1'b1;
          end
        end
        S_PTR_ACK: w_nxt = S_WDATA;
        S_WDATA: begin
          w_bit = 1'b1;
          if (w_last) begin
            w_nxt = S_WDATA_ACK;
            w_wr  = 1'b1;
          end
        end
        S_WDATA_ACK: w_nxt = S_WDATA;
        S_RDATA: begin
          w_tx_bit = 1'b1;
          if (w_last) w_nxt = S_RDATA_ACK;
        end
        S_RDATA_ACK: w_nxt = r_sda_s ? S_IDLE : S_RDATA;
        default: ;
      endcase
    end
    // Level SDA takes after the hold delay following an SCL fall
    unique case (r_state)
      S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: w_pend = 1'b1;
      S_RDATA: w_pend = ~r_tx[7];
      default: w_pend = 1'b0;
    endcase
  end

  assign w_rd_load = (w_nxt == S_RDATA) && (r_state != S_RDATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt       <= '0;
      r_shift      <= '0;
      r_tx         <= '0;
      r_rw         <= 1'b0;
      r_ptr        <= '0;
      r_busy       <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_pend       <= 1'b0;
      r_hold_act   <= 1'b0;
      r_hold_cnt   <= '0;
      r_wr_pulse   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_host_rdata <= '0;
    end else begin
      r_wr_pulse   <= w_wr;
      r_host_rdata <= r_mem[host_addr];
      if (w_start || w_stop) begin
        r_bcnt     <= '0;
        r_sda_oe   <= 1'b0;
        r_hold_act <= 1'b0;
        if (w_stop) r_busy <= 1'b0;
      end else begin
        if (w_bit) begin
          r_shift <= {r_shift[5:0], r_sda_s};
          r_bcnt  <= r_bcnt + 3'd1;
        end
        if (w_tx_bit) begin
          r_tx   <= {r_tx[6:0], 1'b0};
          r_bcnt <= r_bcnt + 3'd1;
        end
        if (w_match) begin
          r_rw   <= r_sda_s;
          r_busy <= 1'b1;
        end
        if (w_ptr_ld) r_ptr <= w_byte[MEM_AW-1:0];
        if (w_wr) begin
          r_wr_addr <= r_ptr;
          r_wr_data <= w_byte;
          r_ptr     <= r_ptr + MEM_AW'(1);
        end
        if (w_rd_load) begin
          r_tx  <= r_mem[r_ptr];
          r_ptr <= r_ptr + MEM_AW'(1);
        end
        if (w_scl_fall) begin
          r_hold_act <= 1'b1;
          r_hold_cnt <= HW'(1);
          r_pend     <= w_pend;
        end else if (r_hold_act) begin
          if (r_hold_cnt == HW'(HOLD_CYC)) begin
            r_sda_oe   <= r_pend;
            r_hold_act <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
      end
    end
  end

  // Bus writes win over a coincident host write
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_ptr] <= w_byte;
    else if (host_we) r_mem[host_addr] <= host_wdata;
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_pulse   = r_wr_pulse;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged bus master, memory/pointer
// reference model and a scoreboard for register writes and read bytes.
module tb_i2c_slave_regfile;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(
    .SLV_ADDR(7'h3c),
    .MEM_AW  (8),
    .HOLD_CYC(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_ptr = '0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  act_rd [$];
  logic [7:0]  tx_q [$];
  bit          watch_oe = 1'b0;
  bit          saw_oe = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (wr_pulse) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: addr %0h data %0h, none expected",
                 wr_addr, wr_data);
      end else begin
        chk("wr_pulse", {16'h0, wr_addr, wr_data}, {16'h0, exp_wr.pop_front()});
      end
    end
    while (act_rd.size() > 0) begin
      logic [7:0] a;
      a = act_rd.pop_front();
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %0h, none expected", a);
      end else begin
        chk("rd_byte", a, exp_rd.pop_front());
      end
    end
    if (watch_oe && sda_oe) saw_oe = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    wclk(1);
    host_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [7:0] d);
    host_addr = a;
    wclk(1);
    d = host_rdata;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wclk(2 * Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b1;
    wclk(Q);
    sda_m = 1'b1;
    wclk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    wclk(Q);
    sda_m = b;
    wclk(Q);
    scl_m = 1'b1;
    wclk(2 * Q);
    scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wclk(1);
    sda_m = 1'b1;
    wclk(2 * Q - 1);
    scl_m = 1'b1;
    wclk(Q);
    b = sda_bus;
    wclk(Q);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic tr_write(input logic [7:0] p);
    logic ack;
    i2c_start();
    send_byte(8'h78, ack);
    chk("w_addr_ack", ack, 1);
    chk("w_busy_set", busy, 1);
    send_byte(p, ack);
    chk("w_ptr_ack", ack, 1);
    ref_ptr = p;
    foreach (tx_q[i]) begin
      exp_wr.push_back({ref_ptr, tx_q[i]});
      ref_mem[ref_ptr] = tx_q[i];
      ref_ptr = ref_ptr + 8'd1;
      send_byte(tx_q[i], ack);
      chk("w_data_ack", ack, 1);
    end
    i2c_stop();
    wclk(2);
    chk("w_busy_clr", busy, 0);
  endtask

  task automatic tr_read(input bit set_ptr, input logic [7:0] p,
                         input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'h78, ack);
      chk("r_waddr_ack", ack, 1);
      send_byte(p, ack);
      chk("r_ptr_ack", ack, 1);
      ref_ptr = p;
      i2c_start();
    end
    send_byte(8'h79, ack);
    chk("r_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(ref_mem[ref_ptr]);
      ref_ptr = ref_ptr + 8'd1;
      recv_byte(i != n - 1, d);
      act_rd.push_back(d);
    end
    wclk(2 * Q);
    chk("r_sda_released", sda_oe, 0);
    chk("r_busy_hold", busy, 1);
    i2c_stop();
    wclk(2);
    chk("r_busy_clr", busy, 0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] p;
    int         n;
    int         k;

    wclk(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_host_rdata", host_rdata, 0);
    rst = 1'b0;
    wclk(4);

    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom));

    // Byte write with pointer
    tx_q = '{8'haa};
    tr_write(8'h03);
    host_read(8'h03, d);
    chk("host_rd_03", d, 8'haa);

    // EEPROM-style random read
    host_write(8'h01, 8'h5c);
    tr_read(1'b1, 8'h01, 1);

    // Address mismatch
    saw_oe = 1'b0;
    watch_oe = 1'b1;
    i2c_start();
    send_byte(8'ha0, ack);
    chk("mis_nack", ack, 0);
    wclk(40);
    chk("mis_busy", busy, 0);
    i2c_stop();
    watch_oe = 1'b0;
    chk("mis_no_oe", saw_oe, 0);

    // Pointer wrap
    tx_q = '{8'h11, 8'h22};
    tr_write(8'hff);
    host_read(8'hff, d);
    chk("wrap_ff", d, 8'h11);
    host_read(8'h00, d);
    chk("wrap_00", d, 8'h22);

    // Sequential read ending with NACK
    host_write(8'h10, 8'h88);
    host_write(8'h11, 8'h77);
    host_write(8'h12, 8'h66);
    host_write(8'h13, 8'h55);
    tr_read(1'b1, 8'h10, 4);

    // Randomized traffic
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 3);
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      if (k == 0) begin
        tx_q = {};
        for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
        tr_write(p);
      end else if (k == 1) begin
        tr_read(1'b1, p, n);
      end else if (k == 2) begin
        tr_read(1'b0, 8'h00, n);
      end else begin
        host_write(p, 8'($urandom));
        tr_read(1'b1, p, n);
      end
    end

    // Reset while driving a 0-bit of read data
    host_write(8'h40, 8'h00);
    i2c_start();
    send_byte(8'h78, ack);
    send_byte(8'h40, ack);
    i2c_start();
    send_byte(8'h79, ack);
    chk("rr_addr_ack", ack, 1);
    k = 0;
    while (!sda_oe && k < 40) begin
      wclk(1);
      k++;
    end
    chk("rr_oe_seen", sda_oe, 1);
    rst = 1'b1;
    wclk(1);
    chk("rr_oe_clr", sda_oe, 0);
    chk("rr_busy_clr", busy, 0);
    rst = 1'b0;
    ref_ptr = 8'h00;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wclk(4 * Q);
    tx_q = '{8'($urandom)};
    tr_write(8'($urandom));
    tr_read(1'b0, 8'h00, 2);

    // Final memory sweep against the model
    for (int i = 0; i < 256; i++) begin
      host_read(8'(i), d);
      chk("sweep", {24'h0, d}, {24'h0, ref_mem[i]});
    end

    wclk(5);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
